countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 78 +++++++
 tb/tb_countdown_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer: loads a start value, subtracts dec on each enabled
// cycle with saturation at zero, then pulses done for one cycle.
module countdown_timer #(
   parameter int N = 8,
   parameter int M = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic [M-1:0] dec,
   input  logic         abort,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         done,
   output logic         zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state, state_d;
   logic [N-1:0] q_d;
   logic [N-1:0] dec_ext;

   // Saturating subtract: results that would go below zero clamp to zero.
   function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
      if (a > b) sat_sub = a - b;
      else       sat_sub = '0;
   endfunction

   assign dec_ext = {{(N-M){1'b0}}, dec};

   // Next-state and next-count decode; abort beats load beats en.
   always_comb begin
      state_d = state;
      q_d     = q;
      if (abort) begin
         state_d = IDLE;
         q_d     = '0;
      end else if (load) begin
         q_d     = load_val;
         state_d = (load_val != '0) ? RUN : DONE;
      end else begin
         case (state)
            RUN: begin
               if (en && (dec_ext != '0)) begin
                  q_d = sat_sub(q, dec_ext);
                  if (q <= dec_ext) state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state;
         endcase
      end
   end

   // State and count registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         q     <= '0;
      end else begin
         state <= state_d;
         q     <= q_d;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign zero = (q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with an expectation queue.
module tb_countdown_timer;

   localparam int N = 8;
   localparam int M = 3;

   logic         clk;
   logic         reset;
   logic         load;
   logic [N-1:0] load_val;
   logic         en;
   logic [M-1:0] dec;
   logic         abort;
   logic [N-1:0] q;
   logic         busy;
   logic         done;
   logic         zero;

   typedef struct {
      logic [N-1:0] q;
      logic         busy;
      logic         done;
      logic         zero;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   countdown_timer #(.N(N), .M(M)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .dec      (dec),
      .abort    (abort),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [N-1:0] eq,
                       input logic eb, input logic ed, input logic ez);
      exp_t e;
      e.q = eq; e.busy = eb; e.done = ed; e.zero = ez;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      assert (q === e.q) else begin
         bad++;
         $error("FAIL %s q: got %0d want %0d", t, q, e.q);
      end
      total++;
      assert (busy === e.busy) else begin
         bad++;
         $error("FAIL %s busy: got %0b want %0b", t, busy, e.busy);
      end
      total++;
      assert (done === e.done) else begin
         bad++;
         $error("FAIL %s done: got %0b want %0b", t, done, e.done);
      end
      total++;
      assert (zero === e.zero) else begin
         bad++;
         $error("FAIL %s zero: got %0b want %0b", t, zero, e.zero);
      end
   endtask

   // Drive inputs after the falling edge, record expectation, check after rise.
   task automatic step(input string tag, input logic l, input logic [N-1:0] lv,
                       input logic e, input logic [M-1:0] d, input logic a,
                       input logic [N-1:0] eq, input logic eb,
                       input logic ed, input logic ez);
      @(negedge clk);
      load = l; load_val = lv; en = e; dec = d; abort = a;
      push(tag, eq, eb, ed, ez);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; dec = '0; abort = 1'b0;
      #12;
      push("reset", 8'd0, 1'b0, 1'b0, 1'b1);
      compare();
      @(negedge clk);
      reset = 1'b1;

      // basic countdown, load wins over en
      step("load3",   1, 8'd3, 1, 3'd1, 0, 8'd3, 1, 0, 0);
      step("cnt2",    0, 8'd0, 1, 3'd1, 0, 8'd2, 1, 0, 0);
      step("cnt1",    0, 8'd0, 1, 3'd1, 0, 8'd1, 1, 0, 0);
      step("cnt0",    0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 1, 1);
      step("idle",    0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 0, 1);
      step("idle_en", 0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 0, 1);

      // saturation
      step("sat_ld5", 1, 8'd5, 0, 3'd4, 0, 8'd5, 1, 0, 0);
      step("sat_1",   0, 8'd0, 1, 3'd4, 0, 8'd1, 1, 0, 0);
      step("sat_0",   0, 8'd0, 1, 3'd4, 0, 8'd0, 0, 1, 1);
      step("sat_idl", 0, 8'd0, 0, 3'd0, 0, 8'd0, 0, 0, 1);

      // full-width dec
      step("d7_ld8",  1, 8'd8, 0, 3'd7, 0, 8'd8, 1, 0, 0);
      step("d7_1",    0, 8'd0, 1, 3'd7, 0, 8'd1, 1, 0, 0);
      step("d7_0",    0, 8'd0, 1, 3'd7, 0, 8'd0, 0, 1, 1);

      // holds: en=0 and dec=0
      step("h_ld6",   1, 8'd6, 0, 3'd1, 0, 8'd6, 1, 0, 0);
      step("h_en0",   0, 8'd0, 0, 3'd1, 0, 8'd6, 1, 0, 0);
      step("h_dec0",  0, 8'd0, 1, 3'd0, 0, 8'd6, 1, 0, 0);

      // abort beats load
      step("ab_ld7",  1, 8'd7, 0, 3'd1, 0, 8'd7, 1, 0, 0);
      step("ab_ld",   1, 8'd9, 1, 3'd1, 1, 8'd0, 0, 0, 1);
      step("ab_post", 0, 8'd0, 0, 3'd1, 0, 8'd0, 0, 0, 1);

      // load of zero goes straight to DONE
      step("z_ld0",   1, 8'd0, 0, 3'd1, 0, 8'd0, 0, 1, 1);
      step("z_post",  0, 8'd0, 0, 3'd1, 0, 8'd0, 0, 0, 1);

      // load and en together
      step("le_ld9",  1, 8'd9, 1, 3'd1, 0, 8'd9, 1, 0, 0);
      step("le_8",    0, 8'd0, 1, 3'd1, 0, 8'd8, 1, 0, 0);

      // reload from DONE
      step("rl_ld1",  1, 8'd1, 0, 3'd1, 0, 8'd1, 1, 0, 0);
      step("rl_done", 0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 1, 1);
      step("rl_ld2",  1, 8'd2, 0, 3'd1, 0, 8'd2, 1, 0, 0);
      step("rl_1",    0, 8'd0, 1, 3'd1, 0, 8'd1, 1, 0, 0);
      step("rl_0",    0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 1, 1);

      // abort in DONE
      step("ad_ld1",  1, 8'd1, 0, 3'd1, 0, 8'd1, 1, 0, 0);
      step("ad_done", 0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 1, 1);
      step("ad_abt",  0, 8'd0, 0, 3'd1, 1, 8'd0, 0, 0, 1);

      // asynchronous reset mid-RUN
      step("ar_ld40", 1, 8'd40, 0, 3'd1, 0, 8'd40, 1, 0, 0);
      step("ar_hold", 0, 8'd0, 0, 3'd1, 0, 8'd40, 1, 0, 0);
      @(negedge clk);
      en = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      push("ar_now", 8'd0, 1'b0, 1'b0, 1'b1);
      compare();
      @(negedge clk);
      reset = 1'b1;
      step("ar_rel1", 0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 0, 1);
      step("ar_rel2", 0, 8'd0, 1, 3'd1, 0, 8'd0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
